// File: rtl/xgmii_loop_pkg.sv
// XGMII control characters, injection FSM states and the idle-word helper
// shared by the loopback channel model.
package xgmii_loop_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    // Widest bus the idle helper can build; callers keep the low DATA_W bits.
    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CORRUPT = 2'd2
    } inj_state_e;

    function automatic logic [MAX_LANES*8-1:0] idle_word(input int lanes);
        logic [MAX_LANES*8-1:0] w;
        w = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) begin
                w[i*8 +: 8] = XGMII_IDLE;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/xgmii_loop_dly.sv
// Circular delay buffer for the XGMII channel: write pointer, delayed read,
// fill tracking and idle blanking after reset or a cfg_delay change.
module xgmii_loop_dly
    import xgmii_loop_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 16,
    localparam int LANES  = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic [DATA_W-1:0] src_d,
    input  logic [LANES-1:0]  src_c,
    input  logic [AW-1:0]     cfg_delay,
    output logic [DATA_W-1:0] load_d,
    output logic [LANES-1:0]  load_c
);

    localparam logic [MAX_LANES*8-1:0] IDLE_FULL = idle_word(LANES);
    localparam logic [DATA_W-1:0]      IDLE_D    = IDLE_FULL[DATA_W-1:0];

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [LANES-1:0]  mem_c [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] fill;
    logic [AW-1:0] dly_q;
    logic          dly_vld;
    logic          dly_chg;
    logic          fill_ok;

    // dly_vld keeps the first cycle after reset from counting as a delay
    // change, so the post-reset blanking is exactly cfg_delay+1 cycles.
    always_comb begin
        rd_idx  = wr_ptr - cfg_delay;
        dly_chg = dly_vld && (cfg_delay != dly_q);
        fill_ok = !dly_chg && (fill == cfg_delay);
        load_d  = IDLE_D;
        load_c  = '1;
        if (fill_ok) begin
            if (cfg_delay == '0) begin
                load_d = src_d;
                load_c = src_c;
            end else begin
                load_d = mem_d[rd_idx];
                load_c = mem_c[rd_idx];
            end
        end
    end

    always_ff @(posedge clk_156m25) begin
        mem_d[wr_ptr] <= src_d;
        mem_c[wr_ptr] <= src_c;
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            wr_ptr  <= '0;
            fill    <= '0;
            dly_q   <= '0;
            dly_vld <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + 1'b1;
            dly_q   <= cfg_delay;
            dly_vld <= 1'b1;
            if (dly_chg) begin
                fill <= '0;
            end else if (fill < cfg_delay) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_loop_chan.sv
// Programmable-latency XGMII TX-to-RX channel with loopback/external source
// select and one-shot error injection. XGMII_LOOP_STATS_EN builds the counters.
module xgmii_loop_chan
    import xgmii_loop_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 16,
    localparam int LANES  = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic [DATA_W-1:0] xgmii_txd,
    input  logic [LANES-1:0]  xgmii_txc,
    input  logic [DATA_W-1:0] ext_rxd,
    input  logic [LANES-1:0]  ext_rxc,
    input  logic              cfg_loop_en,
    input  logic [AW-1:0]     cfg_delay,
    input  logic              inj_req,
    output logic [DATA_W-1:0] xgmii_rxd,
    output logic [LANES-1:0]  xgmii_rxc,
    output logic              inj_busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  inj_cnt
);

    localparam logic [MAX_LANES*8-1:0] IDLE_FULL = idle_word(LANES);
    localparam logic [DATA_W-1:0]      IDLE_D    = IDLE_FULL[DATA_W-1:0];

    inj_state_e        inj_state;
    inj_state_e        inj_state_nxt;
    logic [DATA_W-1:0] sel_d;
    logic [LANES-1:0]  sel_c;
    logic [DATA_W-1:0] wr_d;
    logic [LANES-1:0]  wr_c;
    logic [DATA_W-1:0] load_d;
    logic [LANES-1:0]  load_c;
    logic              sof_src;

    always_comb begin
        sel_d   = cfg_loop_en ? xgmii_txd : ext_rxd;
        sel_c   = cfg_loop_en ? xgmii_txc : ext_rxc;
        sof_src = sel_c[0] && (sel_d[7:0] == XGMII_START);
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            inj_state <= IDLE;
        end else begin
            inj_state <= inj_state_nxt;
        end
    end

    // SOF is looked for only once armed, so a request arriving with an SOF
    // corrupts the following frame rather than this one.
    always_comb begin
        inj_state_nxt = inj_state;
        inj_busy      = (inj_state != IDLE);
        wr_d          = sel_d;
        wr_c          = sel_c;
        case (inj_state)
            IDLE:    if (inj_req) inj_state_nxt = ARMED;
            ARMED:   if (sof_src) inj_state_nxt = CORRUPT;
            CORRUPT: begin
                wr_d[7:0]     = XGMII_ERROR;
                wr_c[0]       = 1'b1;
                inj_state_nxt = IDLE;
            end
            default: inj_state_nxt = IDLE;
        endcase
    end

    xgmii_loop_dly #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dly (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .src_d        (wr_d),
        .src_c        (wr_c),
        .cfg_delay    (cfg_delay),
        .load_d       (load_d),
        .load_c       (load_c)
    );

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            xgmii_rxd <= IDLE_D;
            xgmii_rxc <= '1;
        end else begin
            xgmii_rxd <= load_d;
            xgmii_rxc <= load_c;
        end
    end

`ifdef XGMII_LOOP_STATS_EN
    logic load_sof;

    assign load_sof = load_c[0] && (load_d[7:0] == XGMII_START);

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            frame_cnt <= '0;
            inj_cnt   <= '0;
        end else begin
            if (load_sof && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if ((inj_state == CORRUPT) && (inj_cnt != '1)) begin
                inj_cnt <= inj_cnt + 1'b1;
            end
        end
    end
`else
    assign frame_cnt = '0;
    assign inj_cnt   = '0;
`endif

endmodule
